// File: rtl/jk_pkg.sv
// Shared definitions for the JK-bank counter controller.
//   - Default width/modulo for the counter.
//   - {J,K} excitation encodings.
//   - Modulo legality check used at elaboration.
package jk_pkg;

    localparam int unsigned DefWidth  = 4;
    localparam int unsigned DefModulo = 10;

    // Excitation codes as {J,K}.
    typedef enum logic [1:0] {
        JkHold   = 2'b00,
        JkReset  = 2'b01,
        JkSet    = 2'b10,
        JkToggle = 2'b11
    } jk_exc_e;

    // A modulo is legal when 2 <= modulo <= 2**width.
    function automatic bit modulo_legal(input int unsigned width, input int unsigned modulo);
        longint unsigned span;
        span = longint'(1) << width;
        return (modulo >= 2) && (longint'(modulo) <= span);
    endfunction

endpackage

// File: rtl/jk_ff_bit.sv
// Single JK flip-flop built from a D flip-flop.
//   clk         : rising-edge clock
//   reset_async : asynchronous active-low reset, clears Q
//   J, K        : excitation inputs
//   Q           : stored bit
module jk_ff_bit (
    input  logic clk,
    input  logic reset_async,
    input  logic J,
    input  logic K,
    output logic Q
);

    logic q_q;
    logic q_d;

    // Characteristic equation of a JK flip-flop.
    assign q_d = (J & ~q_q) | (~K & q_q);

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/jk_counter_ctrl.sv
// Mod-MODULO up/down counter whose state lives in a bank of JK flip-flops.
// The controller computes the next count, derives per-bit J/K excitation and
// registers a one-cycle wrap pulse.
//   clk         : rising-edge clock
//   reset_async : asynchronous active-low reset
//   load        : parallel load (highest priority), clamped to MODULO-1
//   load_val    : value to load
//   en          : count enable
//   up          : 1 = increment, 0 = decrement
//   q           : current count from the JK bank
//   j, k        : combinational excitation applied to the bank
//   wrap        : registered pulse in the cycle after a wrap-around
// Build option: define JK_COUNTER_SAT_EN for saturating mode (no wrap, wrap tied low).
module jk_counter_ctrl
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned MODULO = DefModulo
) (
    input  logic             clk,
    input  logic             reset_async,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             wrap
);

    if (!modulo_legal(WIDTH, MODULO)) begin : g_bad_modulo
        $error("jk_counter_ctrl: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] next_cnt;
    logic             wrap_d;
    logic             wrap_q;

    always_comb begin
        next_cnt = q;
        wrap_d   = 1'b0;
        if (load) begin
            next_cnt = (load_val > MaxVal) ? MaxVal : load_val;
        end else if (en) begin
            if (up) begin
                // >= also pulls any out-of-range state back into range.
                if (q >= MaxVal) begin
`ifdef JK_COUNTER_SAT_EN
                    next_cnt = MaxVal;
`else
                    next_cnt = '0;
                    wrap_d   = 1'b1;
`endif
                end else begin
                    next_cnt = q + 1'b1;
                end
            end else begin
                if (q == '0) begin
`ifdef JK_COUNTER_SAT_EN
                    next_cnt = '0;
`else
                    next_cnt = MaxVal;
                    wrap_d   = 1'b1;
`endif
                end else begin
                    next_cnt = q - 1'b1;
                end
            end
        end
    end

    // Only set or clear codes are ever produced; toggle is never used.
    assign j = next_cnt & ~q;
    assign k = ~next_cnt & q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
        jk_ff_bit u_bit (
            .clk         (clk),
            .reset_async (reset_async),
            .J           (j[gi]),
            .K           (k[gi]),
            .Q           (q[gi])
        );
    end

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: doc/jk_counter_ctrl.md
Name: jk_counter_ctrl

Overview:
- Synchronous mod-MODULO up/down counter whose state register is a bank of WIDTH JK flip-flops.
- The block is the controller for that bank. Each cycle it computes the next count and derives the per-bit J/K excitation.
- Supports parallel load, count enable, direction and a registered wrap pulse.
- Serves as the counting/sequencing stage for the chapter-5 sequential examples.

Parameters:
- WIDTH, 4, number of JK state bits.
- MODULO, 10, count range 0..MODULO-1; legal values are 2 <= MODULO <= 2**WIDTH. Illegal values raise an elaboration-time error.

Ports:
- clk  input  1  rising-edge clock.
- reset_async  input  1  asynchronous, active-low reset.
- load  input  1  parallel-load request; highest priority.
- load_val  input  WIDTH  value to load.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- q  output  WIDTH  current count, taken directly from the JK bank outputs.
- j  output  WIDTH  combinational J excitation applied to the bank.
- k  output  WIDTH  combinational K excitation applied to the bank.
- wrap  output  1  registered one-cycle pulse after a wrap-around.

Behaviour:
- Reset (reset_async low, any time, independent of clk):
  - q = 0 and wrap = 0 immediately.
  - The counter stays held while reset_async is low.
  - The first active edge after release evaluates inputs normally.
  - Reset asserted mid-count abandons the count; there is no partial update.
- Next-state selection, evaluated every rising edge, priority load > en > hold:
  - load=1: next = load_val when load_val <= MODULO-1, otherwise next = MODULO-1 (clamp). wrap next = 0.
  - load=0, en=1, up=1: next = q+1. When q >= MODULO-1, next = 0 and wrap next = 1.
  - load=0, en=1, up=0: next = q-1. When q == 0, next = MODULO-1 and wrap next = 1.
  - en=0, load=0: next = q, wrap next = 0.
- Arithmetic is WIDTH bits with no sign. The q >= MODULO-1 compare also recovers any out-of-range state to 0 on the next up-count.
- JK excitation, per bit i, purely combinational from q and next:
  - j[i] = next[i] & ~q[i]
  - k[i] = ~next[i] & q[i]
  - Hold gives J=K=0; set gives J=1,K=0; clear gives J=0,K=1. The toggle code J=K=1 is never produced.
- Latency:
  - q reflects a load or count one clock after the request edge.
  - wrap is high for exactly the cycle following the wrapping edge.
- wrap is low in every cycle that is not immediately after a wrap, including during back-to-back loads.
- Simultaneous load and en: load wins and en is ignored.
- There is no FSM beyond the count register; the state space is the value of q.

Optional Feature:
- Macro JK_COUNTER_SAT_EN.
- Defined: saturating mode.
  - Up-count at MODULO-1 holds at MODULO-1.
  - Down-count at 0 holds at 0.
  - wrap is tied to 0.
  - j/k are all 0 in the saturated hold cycle.
- Undefined: wrap-around behaviour as specified in Behaviour.

Decomposition:
- Shared package/include jk_pkg:
  - Default WIDTH/MODULO constants.
  - Excitation encodings HOLD=2'b00, RESET=2'b01, SET=2'b10, TOGGLE=2'b11 (as {J,K}).
  - MODULO legality-check function.
- Sub-module jk_ff_bit: a single JK flip-flop.
  - Built from a D flip-flop with D = (J & ~Q) | (~K & Q).
  - Ports clk, reset_async, J, K, Q.
  - Instantiated WIDTH times in a generate loop.
- The controller holds only next-state logic, j/k derivation and the wrap register.

Test Plan:
- Reset: count to 5, pulse reset_async low between edges -> q=0 and wrap=0 immediately, with no clk edge needed. After release, en=1, up=1 -> q=1 after the first edge.
- Up wrap (WIDTH=4, MODULO=10): en=1, up=1 from 0 -> q=1..9 then 0. wrap=1 only in the cycle after 9->0. When q=9, j=4'b0000 and k=4'b1001.
- Down wrap: en=1, up=0 from q=0 -> q=9 next cycle, wrap pulses once. At q=0, j=4'b1001 and k=4'b0000.
- Load priority/clamp: load=1, en=1, load_val=7 -> q=7. Then load_val=14 -> q=9 (clamped). wrap stays 0 throughout.
- Hold: en=0, load=0 at q=6 for 3 cycles -> q=6, j=k=0, wrap=0.
- JK_COUNTER_SAT_EN build: up-count from 8 -> 9, 9, 9 with wrap=0. Down from 1 -> 0, 0 with j=k=0.
